ula_result_serializer: RTL and testbench

ULA_RESULT_SERIALIZER -- requirements
Module: ula_result_serializer

---
 rtl/ula_result_serializer.sv | 104 ++++++++++
 tb/tb_ula_result_serializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_result_serializer.sv
// Buffers 2*DATA_WIDTH-bit ULA results in a small FIFO and emits each one as
// two DATA_WIDTH beats (low half, then high half flagged by last_o).
module ula_result_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [2*DATA_WIDTH-1:0]   data_i,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      last_o,
  input  logic                      ready_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      overflow_o,
  input  logic                      clr_ovf_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [2*DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic                      r_ovf;

  logic                      w_full;
  logic                      w_wr;
  logic                      w_drop;
  logic                      w_pop;
  logic [2*DATA_WIDTH-1:0]   w_head;

  // Fullness is judged on the current count, so a drop happens even when
  // the final beat of the head result pops on the same edge.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_wr    = valid_i && !w_full;
  assign w_drop  = valid_i && w_full;
  assign w_pop   = (r_state == HIGH) && ready_i;
  assign w_head  = r_mem[r_rd_ptr];

  assign count_o    = r_count;
  assign overflow_o = r_ovf;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (clr_ovf_i) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    valid_o     = 1'b0;
    data_o      = '0;
    last_o      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wr) w_state_nxt = LOW;
      end
      LOW: begin
        valid_o = 1'b1;
        data_o  = w_head[DATA_WIDTH-1:0];
        if (ready_i) w_state_nxt = HIGH;
      end
      HIGH: begin
        valid_o = 1'b1;
        data_o  = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
        last_o  = 1'b1;
        // Another result follows if one is already queued behind the head
        // or is being written on this very edge.
        if (w_pop) begin
          if ((r_count > CW'(1)) || w_wr) w_state_nxt = LOW;
          else                             w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ula_result_serializer.sv
// Bench for ula_result_serializer: expected beats are queued as stimulus is
// driven and popped by a monitor whenever a beat is accepted.
module tb_ula_result_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        last_o;
  logic        ready_i = 1'b0;
  logic [2:0]  count_o;
  logic        overflow_o;
  logic        clr_ovf_i = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
  } vec_t;

  beat_t sb[$];
  vec_t  tbl[10];
  int    n_chk  = 0;
  int    n_pass = 0;
  logic  mon_en = 1'b1;

  ula_result_serializer #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .ready_i    (ready_i),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .clr_ovf_i  (clr_ovf_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", data_o, last_o);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_data", {24'h0, data_o}, {24'h0, e.d});
        chk("beat_last", {31'h0, last_o}, {31'h0, e.l});
      end
    end
  end

  task automatic push(input logic [15:0] d);
    sb.push_back({d[7:0], 1'b0});
    sb.push_back({d[15:8], 1'b1});
  endtask

  task automatic wr(input logic [15:0] d);
    valid_i = 1'b1;
    data_i  = d;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (sb.size() != 0 && c < maxc) begin
      @(posedge clk);
      c++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    #1;
  endtask

  task automatic clr_pulse();
    clr_ovf_i = 1'b1;
    @(posedge clk); #1;
    clr_ovf_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 10; n++) begin
      tbl[n].din    = 16'h1100 + 16'(n);
      tbl[n].exp_lo = 8'(n);
      tbl[n].exp_hi = 8'h11;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf",   overflow_o, 0);
    chk("rst_data",  data_o, 0);
    chk("rst_last",  last_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single result with one-cycle latency
    ready_i = 1'b1;
    push(16'hA55A);
    wr(16'hA55A);
    chk("latency_valid", valid_o, 1);
    drain(20);
    chk("single_valid_after", valid_o, 0);
    chk("single_count_after", count_o, 0);

    // Backpressure holds the low beat stable
    ready_i = 1'b0;
    push(16'hA55A);
    wr(16'hA55A);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data",  data_o, 8'h5A);
      chk("bp_last",  last_o, 0);
      chk("bp_count", count_o, 1);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    drain(20);
    chk("bp_count_after", count_o, 0);

    // Overflow: fifth result dropped, order preserved, sticky flag cleared
    ready_i = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      if (n <= 4) push(16'(n));
      wr(16'(n));
    end
    chk("ovf_count", count_o, 4);
    chk("ovf_flag",  overflow_o, 1);
    ready_i = 1'b1;
    drain(40);
    chk("ovf_sticky", overflow_o, 1);
    ready_i = 1'b0;
    clr_pulse();
    chk("ovf_cleared", overflow_o, 0);

    // Full while the final beat pops: new result still dropped
    for (int n = 0; n < 4; n++) wr(16'hC1D0 + 16'(n));
    chk("full_count", count_o, 4);
    push(16'hC1D0);
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("full_in_high", last_o, 1);
    valid_i = 1'b1;
    data_i  = 16'hDEAD;
    @(posedge clk); #1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("fullpop_count", count_o, 3);
    chk("fullpop_ovf",   overflow_o, 1);
    for (int n = 1; n < 4; n++) push(16'hC1D0 + 16'(n));
    ready_i = 1'b1;
    drain(40);
    clr_pulse();

    // Streaming with simultaneous write/pop and pointer wrap
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1;
      data_i  = tbl[i].din;
      sb.push_back({tbl[i].exp_lo, 1'b0});
      sb.push_back({tbl[i].exp_hi, 1'b1});
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("stream_count", count_o, 1);
      @(posedge clk); #1;
    end
    drain(40);
    chk("stream_ovf",   overflow_o, 0);
    chk("stream_count_end", count_o, 0);

    // Reset in the middle of a result
    mon_en  = 1'b0;
    ready_i = 1'b0;
    wr(16'hBEEF);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("mid_high_last", last_o, 1);
    chk("mid_high_data", data_o, 8'hBE);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_data",  data_o, 0);
    @(posedge clk); #1;
    rst     = 1'b0;
    mon_en  = 1'b1;
    ready_i = 1'b1;
    push(16'h1234);
    wr(16'h1234);
    drain(20);
    chk("post_rst_count", count_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
